// File: rtl/spi_req_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals around the arbiter.
// The master modport is the arbiter's own view; slave is the surrounding system.
interface spi_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               spi_done;
    logic               spi_start;
    logic [DW-1:0]      spi_data;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic               err;

    modport master (
        input  req, req_data, spi_done,
        output spi_start, spi_data, grant, done, busy, err
    );

    modport slave (
        output req, req_data, spi_done,
        input  spi_start, spi_data, grant, done, busy, err
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin sequencer sharing one SPI write master between NREQ requesters,
// with a guard gap after each transfer and a timeout on missing completions.
module spi_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int GAP     = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    spi_req_arbiter_if.master  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = IW + 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;

    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]   GAP_LOAD  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0]   LAST_INIT = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE       = NREQ'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_ACK,
        ST_GAP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   last_q;
    logic [DW-1:0]   data_q;
    logic [TW-1:0]   to_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            err_q;

    logic [IW-1:0]   winner;
    logic            found;
    logic [SW-1:0]   rr_sum;
    logic [IW-1:0]   rr_cand;
    logic [DW-1:0]   sel_word;
    logic            timeout_hit;
    logic [NREQ-1:0] idx_oh;

    logic            spi_start_d;
    logic [NREQ-1:0] grant_d;
    logic [NREQ-1:0] done_d;
    logic            busy_d;
    logic            err_d;

    assign timeout_hit = (to_cnt == TO_LAST);
    assign idx_oh      = ONE << idx_q;

    // Search starts one past the last served requester and wraps once round.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        rr_sum  = '0;
        rr_cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_sum = {1'b0, last_q} + SW'(k);
            if (rr_sum >= SW'(NREQ)) begin
                rr_sum = rr_sum - SW'(NREQ);
            end
            rr_cand = rr_sum[IW-1:0];
            if (!found && bus.req[rr_cand]) begin
                found  = 1'b1;
                winner = rr_cand;
            end
        end
        sel_word = DW'(bus.req_data >> (int'(winner) * DW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs decode purely from registered state so no input reaches an output.
    always_comb begin
        state_nx    = state;
        spi_start_d = 1'b0;
        grant_d     = '0;
        done_d      = '0;
        busy_d      = 1'b1;
        err_d       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (found) begin
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                spi_start_d = 1'b1;
                grant_d     = idx_oh;
                state_nx    = ST_WAIT;
            end
            ST_WAIT: begin
                grant_d = idx_oh;
                if (bus.spi_done || timeout_hit) begin
                    state_nx = ST_ACK;
                end
            end
            ST_ACK: begin
                grant_d  = idx_oh;
                done_d   = idx_oh;
                err_d    = err_q;
                state_nx = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // A real completion wins over a timeout that expires in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            last_q  <= LAST_INIT;
            data_q  <= '0;
            to_cnt  <= '0;
            gap_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        idx_q  <= winner;
                        data_q <= sel_word;
                    end
                end
                ST_START: begin
                    to_cnt <= '0;
                    err_q  <= 1'b0;
                end
                ST_WAIT: begin
                    if (!bus.spi_done) begin
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    last_q  <= idx_q;
                    gap_cnt <= GAP_LOAD;
                end
                ST_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.spi_start = spi_start_d;
    assign bus.spi_data  = data_q;
    assign bus.grant     = grant_d;
    assign bus.done      = done_d;
    assign bus.busy      = busy_d;
    assign bus.err       = err_d;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: two instances (GAP=8/TIMEOUT=4096 and GAP=0/TIMEOUT=16)
// share one stimulus set; each scenario task checks the selected instance.
module tb_spi_req_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int GAP_A = 8;
    localparam int TO_A  = 4096;
    localparam int GAP_B = 0;
    localparam int TO_B  = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               spi_done;

    int checks = 0;
    int errors = 0;
    int model_last[2];

    spi_req_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus_a ();
    spi_req_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus_b ();

    assign bus_a.req      = req;
    assign bus_a.req_data = req_data;
    assign bus_a.spi_done = spi_done;
    assign bus_b.req      = req;
    assign bus_b.req_data = req_data;
    assign bus_b.spi_done = spi_done;

    spi_req_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(GAP_A), .TIMEOUT(TO_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    spi_req_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(GAP_B), .TIMEOUT(TO_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    always #5 clk = ~clk;

    function automatic logic g_start(input int s);
        return (s == 0) ? bus_a.spi_start : bus_b.spi_start;
    endfunction
    function automatic logic [DW-1:0] g_data(input int s);
        return (s == 0) ? bus_a.spi_data : bus_b.spi_data;
    endfunction
    function automatic logic [NREQ-1:0] g_grant(input int s);
        return (s == 0) ? bus_a.grant : bus_b.grant;
    endfunction
    function automatic logic [NREQ-1:0] g_done(input int s);
        return (s == 0) ? bus_a.done : bus_b.done;
    endfunction
    function automatic logic g_busy(input int s);
        return (s == 0) ? bus_a.busy : bus_b.busy;
    endfunction
    function automatic logic g_err(input int s);
        return (s == 0) ? bus_a.err : bus_b.err;
    endfunction
    function automatic int gap_of(input int s);
        return (s == 0) ? GAP_A : GAP_B;
    endfunction

    // Reference arbitration: first requester after the last one served, wrapping.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        logic [NREQ-1:0] sh;
        for (int k = 1; k <= NREQ; k++) begin
            sh = r >> ((last + k) % NREQ);
            if (sh[0]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic logic [DW-1:0] word_of(input int i);
        logic [NREQ*DW-1:0] t;
        t = req_data >> (i * DW);
        return t[DW-1:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        spi_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_last[0] = NREQ - 1;
        model_last[1] = NREQ - 1;
    endtask

    // One full transfer starting from an IDLE cycle with req already nonzero.
    task automatic serve(input int s, input int delay, input bit drop_early);
        int              exp_idx;
        logic [NREQ-1:0] exp_oh;
        logic [DW-1:0]   exp_data;
        int              cnt;
        int              early_done;
        exp_idx  = rr_pick(model_last[s], req);
        exp_oh   = onehot(exp_idx);
        exp_data = word_of(exp_idx);
        tick();
        checks++;
        if (g_start(s) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL serve%0d_start: got %b expected 1", s, g_start(s));
        end
        checks++;
        if (g_grant(s) !== exp_oh) begin
            errors++;
            $display("[TB] FAIL serve%0d_grant: got %b expected %b", s, g_grant(s), exp_oh);
        end
        checks++;
        if (g_data(s) !== exp_data) begin
            errors++;
            $display("[TB] FAIL serve%0d_data: got %h expected %h", s, g_data(s), exp_data);
        end
        tick();
        checks++;
        if (g_start(s) !== 1'b0 || g_busy(s) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL serve%0d_wait: start %b busy %b expected 0 1", s, g_start(s), g_busy(s));
        end
        if (drop_early) req = req & ~exp_oh;
        early_done = 0;
        repeat (delay) begin
            tick();
            if (g_done(s) !== '0) early_done++;
        end
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        checks++;
        if (early_done != 0) begin
            errors++;
            $display("[TB] FAIL serve%0d_early_done: got %0d pulses expected 0", s, early_done);
        end
        checks++;
        if (g_done(s) !== exp_oh || g_err(s) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL serve%0d_done: got %b err %b expected %b err 0", s, g_done(s), g_err(s), exp_oh);
        end
        checks++;
        if (g_data(s) !== exp_data) begin
            errors++;
            $display("[TB] FAIL serve%0d_data_hold: got %h expected %h", s, g_data(s), exp_data);
        end
        req = req & ~exp_oh;
        model_last[s] = exp_idx;
        tick();
        checks++;
        if (g_done(s) !== '0 || g_grant(s) !== '0) begin
            errors++;
            $display("[TB] FAIL serve%0d_release: done %b grant %b expected 0 0", s, g_done(s), g_grant(s));
        end
        cnt = 0;
        while (g_busy(s) === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != gap_of(s)) begin
            errors++;
            $display("[TB] FAIL serve%0d_gap: got %0d busy cycles expected %0d", s, cnt, gap_of(s));
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({g_start(s), g_data(s), g_grant(s), g_done(s), g_busy(s), g_err(s)} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs%0d: got %h expected 0", s,
                         {g_start(s), g_data(s), g_grant(s), g_done(s), g_busy(s), g_err(s)});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        req_data = '0;
        req_data[DW-1:0] = 16'hA5C3;
        req = 4'b0001;
        serve(0, 20, 1'b0);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int j = 0; j < NREQ; j++) req_data[j*DW +: DW] = DW'($urandom);
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) serve(0, $urandom_range(0, 5), 1'b0);
        req = 4'b1001;
        serve(0, 1, 1'b0);
        serve(0, 2, 1'b0);
    endtask

    task automatic test_timeout();
        int              exp_idx;
        logic [NREQ-1:0] exp_oh;
        int              cnt;
        do_reset();
        for (int j = 0; j < NREQ; j++) req_data[j*DW +: DW] = DW'($urandom);
        req = 4'b0100;
        exp_idx = rr_pick(model_last[1], req);
        exp_oh  = onehot(exp_idx);
        tick();
        checks++;
        if (g_start(1) !== 1'b1 || g_grant(1) !== exp_oh) begin
            errors++;
            $display("[TB] FAIL timeout_start: start %b grant %b expected 1 %b", g_start(1), g_grant(1), exp_oh);
        end
        tick();
        cnt = 0;
        while (g_done(1) === '0 && cnt < 40) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt != TO_B) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", cnt, TO_B);
        end
        checks++;
        if (g_err(1) !== 1'b1 || g_done(1) !== exp_oh) begin
            errors++;
            $display("[TB] FAIL timeout_ack: err %b done %b expected 1 %b", g_err(1), g_done(1), exp_oh);
        end
        req = req & ~exp_oh;
        model_last[1] = exp_idx;
        tick();
        checks++;
        if (g_err(1) !== 1'b0 || g_done(1) !== '0 || g_busy(1) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_after: err %b done %b busy %b expected 0 0 0", g_err(1), g_done(1), g_busy(1));
        end
    endtask

    task automatic test_ignored_done();
        int cnt;
        int seen;
        do_reset();
        for (int j = 0; j < NREQ; j++) req_data[j*DW +: DW] = DW'($urandom);
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        tick();
        checks++;
        if (g_busy(0) !== 1'b0 || g_done(0) !== '0) begin
            errors++;
            $display("[TB] FAIL ignore_idle: busy %b done %b expected 0 0", g_busy(0), g_done(0));
        end
        req = 4'b0010;
        tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        seen = 0;
        repeat (3) begin
            if (g_done(0) !== '0 || g_busy(0) !== 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL ignore_start: got %0d bad cycles expected 0", seen);
        end
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        checks++;
        if (g_done(0) !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL ignore_real_done: got %b expected 0010", g_done(0));
        end
        req = '0;
        tick();
        cnt  = 0;
        seen = 0;
        while (g_busy(0) === 1'b1 && cnt < 40) begin
            spi_done = 1'b1;
            if (g_done(0) !== '0) seen++;
            cnt++;
            tick();
        end
        spi_done = 1'b0;
        checks++;
        if (cnt != GAP_A || seen != 0) begin
            errors++;
            $display("[TB] FAIL ignore_gap: got %0d gap %0d done expected %0d 0", cnt, seen, GAP_A);
        end
        tick();
        checks++;
        if (g_busy(0) !== 1'b0 || g_done(0) !== '0) begin
            errors++;
            $display("[TB] FAIL ignore_settle: busy %b done %b expected 0 0", g_busy(0), g_done(0));
        end
    endtask

    task automatic test_back_to_back();
        int e0;
        int e1;
        do_reset();
        for (int j = 0; j < NREQ; j++) req_data[j*DW +: DW] = DW'($urandom);
        req = 4'b0011;
        e0  = rr_pick(model_last[1], req);
        tick();
        tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        checks++;
        if (g_done(1) !== onehot(e0)) begin
            errors++;
            $display("[TB] FAIL b2b_done0: got %b expected %b", g_done(1), onehot(e0));
        end
        req = req & ~onehot(e0);
        model_last[1] = e0;
        e1 = rr_pick(e0, req);
        tick();
        checks++;
        if (g_start(1) !== 1'b0 || g_busy(1) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: start %b busy %b expected 0 0", g_start(1), g_busy(1));
        end
        tick();
        checks++;
        if (g_start(1) !== 1'b1 || g_grant(1) !== onehot(e1) || g_data(1) !== word_of(e1)) begin
            errors++;
            $display("[TB] FAIL b2b_start1: start %b grant %b data %h expected 1 %b %h",
                     g_start(1), g_grant(1), g_data(1), onehot(e1), word_of(e1));
        end
        tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        checks++;
        if (g_done(1) !== onehot(e1)) begin
            errors++;
            $display("[TB] FAIL b2b_done1: got %b expected %b", g_done(1), onehot(e1));
        end
        req = req & ~onehot(e1);
        model_last[1] = e1;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int j = 0; j < NREQ; j++) req_data[j*DW +: DW] = DW'($urandom);
        req = 4'b0100;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({g_start(0), g_data(0), g_grant(0), g_done(0), g_busy(0), g_err(0)} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %h expected 0",
                     {g_start(0), g_data(0), g_grant(0), g_done(0), g_busy(0), g_err(0)});
        end
        rst = 1'b0;
        model_last[0] = NREQ - 1;
        model_last[1] = NREQ - 1;
        serve(0, 2, 1'b0);
    endtask

    task automatic test_random(input int s, input int n);
        do_reset();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < NREQ; j++) req_data[j*DW +: DW] = DW'($urandom);
            if ($urandom_range(0, 2) == 0) req = NREQ'($urandom);
            else req = req | NREQ'($urandom);
            if (req == '0) req = onehot($urandom_range(0, NREQ - 1));
            serve(s, $urandom_range(0, 8), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        spi_done = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_ignored_done();
        test_back_to_back();
        test_reset_mid();
        test_random(1, 25);
        test_random(0, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
